// File: rtl/hdmi_line_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_line_fetch
//  Description : Pixel prefetch stage for the HDMI output core. Turns the
//                core's frame/line strobes into credit-limited burst reads,
//                buffers returned words in a FIFO and serves one word per pop.
//                Optional macro HDMI_FETCH_UFCNT_EN adds a saturating 16-bit
//                count of empty pops on port underflow_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module hdmi_line_fetch #(
    parameter int unsigned DEPTH           = 256,
    parameter int unsigned BURST           = 64,
    parameter logic [31:0] UNDERFLOW_COLOR = 32'h0000_0000
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [31:0]             base_addr,
    input  logic [10:0]             hres,
    input  logic                    read_go,
    input  logic                    read_next_line,
    input  logic                    read_done,
    input  logic                    pix_pop,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic [31:0]             req_addr,
    output logic [7:0]              req_len,
    input  logic [31:0]             mem_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    output logic [31:0]             color,
    output logic                    underflow,
`ifdef HDMI_FETCH_UFCNT_EN
    output logic [15:0]             underflow_count,
`endif
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    // Wide enough that level + outstanding + burst can never overflow.
    localparam int unsigned CW = AW + 10;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [10:0]   BURST_W    = 11'(BURST);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FETCH     = 2'd1,
        ST_LINE_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     line_addr_q, line_addr_d;
    logic [10:0]     words_left_q, words_left_d;
    logic [10:0]     hres_q, hres_d;
    logic [LW-1:0]   outstanding_q, outstanding_d;
    logic            pend_line_q, pend_line_d;
    logic            req_valid_q, req_valid_d;
    // Set when the presented request belongs to an aborted/restarted session:
    // its acceptance still counts as outstanding data but must not move the
    // new session's address or word counters.
    logic            req_stale_q, req_stale_d;
    logic [31:0]     req_addr_q, req_addr_d;
    logic [7:0]      req_len_q, req_len_d;
    logic [31:0]     color_q, color_d;
    logic            underflow_q, underflow_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
`ifdef HDMI_FETCH_UFCNT_EN
    logic [15:0]     ufcnt_q, ufcnt_d;
`endif

    logic            accept;
    logic            mem_fire;
    logic            pop_ok;
    logic            fifo_wr;
    logic            flush;
    logic [7:0]      burst_n;
    logic [31:0]     fifo_mem [DEPTH];

    // Pixel storage; no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_q] <= mem_data;
        end
    end

    // Next-state, request issue, FIFO and pop datapath.
    always_comb begin
        state_d       = state_q;
        line_addr_d   = line_addr_q;
        words_left_d  = words_left_q;
        hres_d        = hres_q;
        outstanding_d = outstanding_q;
        pend_line_d   = pend_line_q;
        req_valid_d   = req_valid_q;
        req_stale_d   = req_stale_q;
        req_addr_d    = req_addr_q;
        req_len_d     = req_len_q;
        color_d       = color_q;
        underflow_d   = underflow_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
`ifdef HDMI_FETCH_UFCNT_EN
        ufcnt_d       = ufcnt_q;
`endif
        flush         = 1'b0;
        burst_n       = 8'd0;

        accept   = req_valid_q && req_ready;
        mem_fire = mem_valid && mem_ready;
        pop_ok   = pix_pop && (level_q != '0);

        if (accept) begin
            req_valid_d   = 1'b0;
            req_stale_d   = 1'b0;
            outstanding_d = outstanding_d + LW'(req_len_q);
            if (!req_stale_q) begin
                line_addr_d  = line_addr_q + {22'd0, req_len_q, 2'b00};
                words_left_d = words_left_q - {3'd0, req_len_q};
            end
        end
        if (mem_fire) begin
            outstanding_d = outstanding_d - LW'(1);
        end

        if (pix_pop) begin
            if (pop_ok) begin
                color_d  = fifo_mem[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                color_d     = UNDERFLOW_COLOR;
                underflow_d = 1'b1;
`ifdef HDMI_FETCH_UFCNT_EN
                if (ufcnt_q != 16'hFFFF) begin
                    ufcnt_d = ufcnt_q + 16'd1;
                end
`endif
            end
        end

        // Data returning while idle belongs to an abandoned frame.
        fifo_wr = mem_fire && (state_q != ST_IDLE);

        if (!start) begin
            state_d     = ST_IDLE;
            flush       = 1'b1;
            underflow_d = 1'b0;
`ifdef HDMI_FETCH_UFCNT_EN
            ufcnt_d     = 16'd0;
`endif
        end else if (read_go) begin
            state_d      = ST_FETCH;
            flush        = 1'b1;
            underflow_d  = 1'b0;
            line_addr_d  = base_addr;
            words_left_d = hres;
            hres_d       = hres;
`ifdef HDMI_FETCH_UFCNT_EN
            ufcnt_d      = 16'd0;
`endif
        end else if (read_done && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            flush   = 1'b1;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (read_next_line) begin
                        pend_line_d = 1'b1;
                    end
                    if ((words_left_d == 11'd0) && !req_valid_d) begin
                        // A line request that arrived early restarts fetch at once.
                        if (pend_line_d) begin
                            words_left_d = hres_q;
                            pend_line_d  = 1'b0;
                        end else begin
                            state_d = ST_LINE_WAIT;
                        end
                    end
                end
                ST_LINE_WAIT: begin
                    if (read_next_line) begin
                        words_left_d = hres_q;
                        state_d      = ST_FETCH;
                    end
                end
                default: begin
                end
            endcase
        end

        if (flush) begin
            fifo_wr     = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            pend_line_d = 1'b0;
            req_stale_d = req_valid_d;
        end
        if (fifo_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        level_d = flush ? '0 : (level_q + LW'(fifo_wr) - LW'(pop_ok));

        // Issue only when every word of the burst already has a FIFO slot.
        burst_n = (words_left_d > BURST_W) ? 8'(BURST) : words_left_d[7:0];
        if ((state_d == ST_FETCH) && !req_valid_d && (words_left_d != 11'd0) &&
            ((CW'(level_d) + CW'(outstanding_d) + CW'(burst_n)) <= CW'(DEPTH))) begin
            req_valid_d = 1'b1;
            req_addr_d  = line_addr_d;
            req_len_d   = burst_n;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            line_addr_q   <= '0;
            words_left_q  <= '0;
            hres_q        <= '0;
            outstanding_q <= '0;
            pend_line_q   <= 1'b0;
            req_valid_q   <= 1'b0;
            req_stale_q   <= 1'b0;
            req_addr_q    <= '0;
            req_len_q     <= '0;
            color_q       <= '0;
            underflow_q   <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
`ifdef HDMI_FETCH_UFCNT_EN
            ufcnt_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            line_addr_q   <= line_addr_d;
            words_left_q  <= words_left_d;
            hres_q        <= hres_d;
            outstanding_q <= outstanding_d;
            pend_line_q   <= pend_line_d;
            req_valid_q   <= req_valid_d;
            req_stale_q   <= req_stale_d;
            req_addr_q    <= req_addr_d;
            req_len_q     <= req_len_d;
            color_q       <= color_d;
            underflow_q   <= underflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
`ifdef HDMI_FETCH_UFCNT_EN
            ufcnt_q       <= ufcnt_d;
`endif
        end
    end

    assign req_valid = req_valid_q;
    assign req_addr  = req_addr_q;
    assign req_len   = req_len_q;
    assign color     = color_q;
    assign underflow = underflow_q;
    assign level     = level_q;
    assign mem_ready = (level_q != FULL_LEVEL);
`ifdef HDMI_FETCH_UFCNT_EN
    assign underflow_count = ufcnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hdmi_line_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hdmi_line_fetch
//  Description : Randomized self-checking bench for hdmi_line_fetch with a
//                transaction-level reference model (queues for FIFO contents,
//                returning memory data and the expected request stream).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_line_fetch;

    localparam int          DEPTH = 256;
    localparam int          BURST = 64;
    localparam logic [31:0] UFC   = 32'hDEAD_0BAD;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] base_addr;
    logic [10:0] hres;
    logic        read_go, read_next_line, read_done, pix_pop;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [31:0] mem_data;
    logic        mem_valid, mem_ready;
    logic [31:0] color;
    logic        underflow;
    logic [8:0]  level;
`ifdef HDMI_FETCH_UFCNT_EN
    logic [15:0] underflow_count;
`endif

    hdmi_line_fetch #(
        .DEPTH           (DEPTH),
        .BURST           (BURST),
        .UNDERFLOW_COLOR (UFC)
    ) u_dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .base_addr       (base_addr),
        .hres            (hres),
        .read_go         (read_go),
        .read_next_line  (read_next_line),
        .read_done       (read_done),
        .pix_pop         (pix_pop),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_len         (req_len),
        .mem_data        (mem_data),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .color           (color),
        .underflow       (underflow),
`ifdef HDMI_FETCH_UFCNT_EN
        .underflow_count (underflow_count),
`endif
        .level           (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] fifo_q [$];
    logic [31:0] mq_data [$];
    int          mq_due [$];
    int          m_out = 0;
    bit          m_active = 0;
    bit          m_uf = 0;
    logic [15:0] m_ufcnt = 16'd0;
    logic [31:0] m_color = 32'd0;
    logic [31:0] exp_addr = 32'd0;
    int          exp_left = 0;
    int          credits = 0;
    int          m_hres = 0;
    int          pop_pct = 0;
    int          rdy_pct = 100;
    int          mem_pct = 90;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: choose random handshakes, advance, update model, compare.
    task automatic cycle();
        logic        p_rv, p_rr, p_mv, p_mr, p_pop, p_go, p_nl, p_done, p_start;
        logic [31:0] p_addr, w;
        logic [7:0]  p_len;
        bit          flush;
        int          n;
        int          due;

        pix_pop   = start && !read_go && !read_done && ($urandom_range(0, 99) < pop_pct);
        req_ready = ($urandom_range(0, 99) < rdy_pct);
        p_rv = req_valid; p_rr = req_ready; p_addr = req_addr; p_len = req_len;
        p_mv = mem_valid; p_mr = mem_ready; p_pop = pix_pop;
        p_go = read_go; p_nl = read_next_line; p_done = read_done; p_start = start;
        w = 32'd0;

        @(posedge clock);
        #1;
        cyc++;

        if (p_rv && p_rr) begin
            for (int i = 0; i < int'(p_len); i++) begin
                mq_data.push_back($urandom);
                mq_due.push_back(cyc + 2);
            end
            m_out += int'(p_len);
        end
        flush = !p_start || p_go || (p_done && m_active);
        if (p_mv && p_mr) begin
            w   = mq_data.pop_front();
            due = mq_due.pop_front();
            m_out--;
        end
        if (p_pop) begin
            if (fifo_q.size() > 0) begin
                m_color = fifo_q.pop_front();
            end else begin
                m_color = UFC;
                m_uf    = 1'b1;
                if (m_ufcnt != 16'hFFFF) m_ufcnt++;
            end
        end
        if (p_mv && p_mr && m_active && !flush) fifo_q.push_back(w);
        if (flush) fifo_q.delete();
        if (!p_start) begin
            m_active = 0; m_uf = 0; m_ufcnt = 16'd0; credits = 0; exp_left = 0;
        end else if (p_go) begin
            m_active = 1; m_uf = 0; m_ufcnt = 16'd0; credits = 0;
            exp_addr = base_addr; exp_left = int'(hres); m_hres = int'(hres);
        end else if (p_done && m_active) begin
            m_active = 0;
        end else if (p_nl && m_active) begin
            credits++;
        end

        check_eq("color", color, m_color);
        check_eq("level", 32'(level), fifo_q.size());
        check_eq("underflow", 32'(underflow), 32'(m_uf));
        check_eq("mem_ready", 32'(mem_ready), 32'(fifo_q.size() != DEPTH));
`ifdef HDMI_FETCH_UFCNT_EN
        check_eq("underflow_count", 32'(underflow_count), 32'(m_ufcnt));
`endif

        if (p_rv && !p_rr) begin
            check_eq("req_hold_valid", 32'(req_valid), 32'd1);
            check_eq("req_hold_addr", req_addr, p_addr);
            check_eq("req_hold_len", 32'(req_len), 32'(p_len));
        end else if (req_valid) begin
            if (!m_active) begin
                check_eq("req_while_idle", 32'(req_valid), 32'd0);
            end else begin
                if (exp_left == 0 && credits > 0) begin
                    exp_left = m_hres;
                    credits--;
                end
                n = (exp_left < BURST) ? exp_left : BURST;
                check_eq("req_addr", req_addr, exp_addr);
                check_eq("req_len", 32'(req_len), n);
                check_eq("req_credit", 32'(fifo_q.size() + m_out + int'(req_len) <= DEPTH), 32'd1);
                exp_addr = exp_addr + 32'(4 * n);
                exp_left = exp_left - n;
            end
        end

        if (mq_data.size() > 0 && mq_due[0] <= cyc && $urandom_range(0, 99) < mem_pct) begin
            mem_valid = 1'b1;
            mem_data  = mq_data[0];
        end else begin
            mem_valid = 1'b0;
            mem_data  = $urandom;
        end
        read_go = 1'b0; read_next_line = 1'b0; read_done = 1'b0;
    endtask

    task automatic run_phase(input int ncyc, input int pp, input int rp, input int nlp);
        pop_pct = pp;
        rdy_pct = rp;
        for (int i = 0; i < ncyc; i++) begin
            if (m_active && credits == 0 && $urandom_range(0, 99) < nlp) read_next_line = 1'b1;
            cycle();
        end
    endtask

    // Run until every signalled line has been fully requested and returned.
    task automatic drain(input string tag);
        int k;
        k = 0;
        pop_pct = 100;
        rdy_pct = 100;
        while (!((!m_active || (exp_left == 0 && credits == 0)) &&
                 mq_data.size() == 0 && !req_valid) && k < 4000) begin
            cycle();
            k++;
        end
        check_eq(tag, 32'(k < 4000), 32'd1);
    endtask

    task automatic go(input logic [31:0] b, input logic [10:0] h);
        base_addr = b;
        hres      = h;
        read_go   = 1'b1;
        cycle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        int   hres_tab [4];
        hres_tab = '{1, 64, 65, 128};

        reset_n = 1'b0; start = 1'b0; base_addr = '0; hres = '0;
        read_go = 1'b0; read_next_line = 1'b0; read_done = 1'b0; pix_pop = 1'b0;
        req_ready = 1'b0; mem_valid = 1'b0; mem_data = '0;

        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_req_valid", 32'(req_valid), 32'd0);
        check_eq("rst_req_addr", req_addr, 32'd0);
        check_eq("rst_req_len", 32'(req_len), 32'd0);
        check_eq("rst_color", color, 32'd0);
        check_eq("rst_underflow", 32'(underflow), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_mem_ready", 32'(mem_ready), 32'd1);
        reset_n = 1'b1;
        start   = 1'b1;

        // Empty pops while idle.
        run_phase(4, 100, 100, 0);

        // Basic fill, then a line request while still fetching.
        go(32'h0000_1000, 11'd800);
        run_phase(400, 0, 100, 0);
        check_eq("fill_level", 32'(level), DEPTH);
        read_next_line = 1'b1;
        cycle();
        run_phase(600, 90, 90, 0);
        drain("drain_two_lines");
        // Line request from LINE_WAIT, then random line traffic.
        read_next_line = 1'b1;
        cycle();
        run_phase(900, 80, 80, 5);
        drain("drain_random_lines");

        // Boundary line widths, first one wrapping the address space.
        for (int t = 0; t < 4; t++) begin
            go((t == 0) ? 32'hFFFF_FFC0 : $urandom, 11'(hres_tab[t]));
            run_phase(300, 70, 80, 15);
            drain("drain_hres_tab");
        end

        // Abort with a request held back by req_ready.
        go(32'h0000_2000, 11'd800);
        run_phase(20, 0, 100, 0);
        pop_pct = 100;
        rdy_pct = 0;
        k = 0;
        while (!req_valid && k < 400) begin
            cycle();
            k++;
        end
        check_eq("abort_req_seen", 32'(req_valid), 32'd1);
        read_done = 1'b1;
        cycle();
        run_phase(10, 50, 0, 0);
        run_phase(60, 0, 100, 0);
        check_eq("abort_req_dropped", 32'(req_valid), 32'd0);
        check_eq("abort_level", 32'(level), 32'd0);

        // start low behaves like an abort and clears the sticky flag.
        go($urandom, 11'($urandom_range(100, 900)));
        run_phase(60, 60, 100, 0);
        run_phase(300, 100, 0, 0);
        start = 1'b0;
        run_phase(5, 0, 100, 0);
        check_eq("start_low_uf", 32'(underflow), 32'd0);
        start = 1'b1;
        run_phase(100, 0, 100, 0);

        // Asynchronous reset in the middle of a burst.
        go(32'h0000_4000, 11'd800);
        run_phase(30, 50, 100, 0);
        pix_pop = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_req_valid", 32'(req_valid), 32'd0);
        check_eq("arst_req_addr", req_addr, 32'd0);
        check_eq("arst_req_len", 32'(req_len), 32'd0);
        check_eq("arst_color", color, 32'd0);
        check_eq("arst_underflow", 32'(underflow), 32'd0);
        check_eq("arst_level", 32'(level), 32'd0);
        check_eq("arst_mem_ready", 32'(mem_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
